// File: rtl/lg_gate_pkg.sv
// Shared encodings for the lg_gate family: OP width, OP codes and the gate enumeration.
package lg_gate_pkg;

    localparam int LG_OP_W = 3;

    localparam logic [LG_OP_W-1:0] LG_OP_INV  = 3'd0;
    localparam logic [LG_OP_W-1:0] LG_OP_BUF  = 3'd1;
    localparam logic [LG_OP_W-1:0] LG_OP_AND  = 3'd2;
    localparam logic [LG_OP_W-1:0] LG_OP_OR   = 3'd3;
    localparam logic [LG_OP_W-1:0] LG_OP_NAND = 3'd4;
    localparam logic [LG_OP_W-1:0] LG_OP_NOR  = 3'd5;
    localparam logic [LG_OP_W-1:0] LG_OP_XOR  = 3'd6;
    localparam logic [LG_OP_W-1:0] LG_OP_XNOR = 3'd7;

    typedef enum logic [LG_OP_W-1:0] {
        LG_INV  = LG_OP_INV,
        LG_BUF  = LG_OP_BUF,
        LG_AND  = LG_OP_AND,
        LG_OR   = LG_OP_OR,
        LG_NAND = LG_OP_NAND,
        LG_NOR  = LG_OP_NOR,
        LG_XOR  = LG_OP_XOR,
        LG_XNOR = LG_OP_XNOR
    } lg_gate_e;

endpackage

// File: rtl/lg_gate_func.sv
// Combinational bitwise gate: selects one of eight 74-series functions of A/B by OP.
module lg_gate_func
    import lg_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [LG_OP_W-1:0] i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   o_y
);

    lg_gate_e w_sel;

    assign w_sel = lg_gate_e'(i_op);

    always_comb begin
        o_y = '0;
        case (w_sel)
            LG_INV:  o_y = ~i_a;
            LG_BUF:  o_y = i_a;
            LG_AND:  o_y = i_a & i_b;
            LG_OR:   o_y = i_a | i_b;
            LG_NAND: o_y = ~(i_a & i_b);
            LG_NOR:  o_y = ~(i_a | i_b);
            LG_XOR:  o_y = i_a ^ i_b;
            LG_XNOR: o_y = ~(i_a ^ i_b);
            default: o_y = '0;
        endcase
    end

endmodule

// File: rtl/lg_gate_pipe.sv
// Registered gate lane with valid/ready handshake, one-deep result register and accept counter.
// Optional Y_PAR (XOR-reduction of Y) when LG_GATE_PARITY_EN is defined.
module lg_gate_pipe
    import lg_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LG_OP_W-1:0] OP,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Y,
    output logic [LG_OP_W-1:0] Y_OP,
    output logic [CNT_W-1:0]   xfer_cnt
`ifdef LG_GATE_PARITY_EN
    ,
    output logic               Y_PAR
`endif
);

    logic               r_valid;
    logic [WIDTH-1:0]   r_y;
    logic [LG_OP_W-1:0] r_op;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   w_f;
    logic               w_accept;

    lg_gate_func #(.WIDTH(WIDTH)) u_func (
        .i_op (OP),
        .i_a  (A),
        .i_b  (B),
        .o_y  (w_f)
    );

    // Output slot frees up when empty or being drained this cycle.
    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_y     <= w_f;
            r_op    <= OP;
            r_cnt   <= r_cnt + CNT_W'(1);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

`ifdef LG_GATE_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^w_f;
        end
    end

    assign Y_PAR = r_par;
`endif

    assign out_valid = r_valid;
    assign Y         = r_y;
    assign Y_OP      = r_op;
    assign xfer_cnt  = r_cnt;

endmodule

// File: doc/lg_gate_pipe.md
Name: lg_gate_pipe

Overview:
- Parametrised, registered successor to the single-bit discrete-gate blocks.
- One W-bit two-operand lane applies one of eight selectable gate functions: INV, BUF, AND, OR, NAND, NOR, XOR, XNOR.
- Valid/ready handshake on input and output, one-stage result register with backpressure, and a transaction counter.
- Sits between stimulus/bus logic and downstream consumers that need clean, registered 74-series gate behaviour at any width.

Parameters:
- WIDTH, 8: operand and result width in bits (>=1).
- CNT_W, 16: width of accepted-transaction counter (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- in_valid  input  1  A/B/OP valid this cycle
- in_ready  output  1  block can accept this cycle
- OP  input  3  gate select: 0 INV, 1 BUF, 2 AND, 3 OR, 4 NAND, 5 NOR, 6 XOR, 7 XNOR
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B (ignored for INV/BUF)
- out_valid  output  1  Y/Y_OP hold a result
- out_ready  input  1  consumer takes result this cycle
- Y  output  WIDTH  registered result
- Y_OP  output  3  OP that produced Y
- xfer_cnt  output  CNT_W  count of accepted inputs

Behaviour:
- Reset (asynchronous, active-high, any time incl. mid-transfer):
  - out_valid=0, Y=0, Y_OP=0, xfer_cnt=0.
  - Any pending result is discarded.
  - in_ready=1 in the first cycle after deassertion.
- in_ready = !out_valid || out_ready (combinational; no input-to-input path other than out_ready).
- Accept = in_valid && in_ready. On accept, at the next rising edge:
  - Y <= f(OP,A,B); Y_OP <= OP; out_valid <= 1; xfer_cnt <= xfer_cnt+1.
- Latency: exactly 1 cycle from accept to out_valid.
- Gate functions, bitwise over WIDTH:
  - INV ~A; BUF A; AND A&B; OR A|B.
  - NAND ~(A&B); NOR ~(A|B); XOR A^B; XNOR ~(A^B).
- Drain = out_valid && out_ready:
  - Drain without accept: out_valid <= 0; Y and Y_OP keep their last value.
  - Drain and accept in the same cycle: new result replaces old; out_valid stays 1 (full throughput, one result per cycle).
- Backpressure: while out_valid && !out_ready, Y, Y_OP and out_valid hold stable; in_ready=0; A/B/OP are ignored.
- in_valid with in_ready=0: no state change and no count. The producer must hold its data until accepted.
- xfer_cnt wraps modulo 2^CNT_W with no saturation or flag.
- All OP encodings are legal; there is no error state.
- WIDTH=1 must reproduce the discrete single-gate truth tables exactly, registered by one cycle.

Optional Feature:
- Macro LG_GATE_PARITY_EN.
- Defined:
  - Adds output Y_PAR (1 bit), registered alongside Y and equal to XOR-reduction of the new Y.
  - Y_PAR has the same hold, reset (0) and update rules as Y.
- Undefined:
  - Y_PAR port and its register are absent.
  - All other behaviour is identical.

Decomposition:
- Package lg_gate_pkg:
  - localparams for the eight OP encodings (LG_OP_INV .. LG_OP_XNOR) and OP width constant 3.
  - Gate enumeration typedef.
- Sub-module lg_gate_func, purely combinational, parameter WIDTH: OP/A/B -> result. Reusable by other gate-family blocks.
- lg_gate_pipe holds the handshake, registers and counter.

Test Plan:
- Reset: assert rst mid-stream with out_valid=1 -> same cycle out_valid=0, Y=0x00, xfer_cnt=0; after release in_ready=1.
- Unary: OP=0 A=0xA5 -> next cycle Y=0x5A, Y_OP=0. Then OP=1 A=0x3C B=0xFF -> Y=0x3C.
- Binary sweep with A=0xF0, B=0xCC:
  - AND 0xC0, OR 0xFC, NAND 0x3F, NOR 0x03, XOR 0x3C, XNOR 0xC3.
  - Back-to-back with out_ready=1: one result per cycle, xfer_cnt=6.
- Backpressure: out_ready=0, send XOR 0x0F/0xFF then a second word -> Y=0xF0 held, in_ready=0, xfer_cnt=1. Raise out_ready -> second word accepted the same cycle, xfer_cnt=2.
- Wrap: CNT_W=4, 17 accepts -> xfer_cnt=1.
- Parity (LG_GATE_PARITY_EN): OP=1 A=0x07 -> Y_PAR=1. A=0x03 -> Y_PAR=0. Without the macro, the build has no Y_PAR and results match the non-parity build.
